// File: rtl/tb_run_ctrl.sv
// Bench run controller: sequences core reset release and fetch enable, folds per-core
// pass/fail flags into one sticky verdict, and enforces a RUN-state cycle watchdog.
module tb_run_ctrl #(
  parameter int unsigned NUM_CORES          = 1,
  parameter int unsigned RESET_WAIT_CYCLES  = 4,
  parameter int unsigned FETCH_DELAY_CYCLES = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 1000000,
  parameter int unsigned CNT_W              = 32,
  parameter int unsigned FAIL_FAST          = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rerun_req_i,
  input  logic [NUM_CORES-1:0] tests_passed_i,
  input  logic [NUM_CORES-1:0] tests_failed_i,
  output logic                 core_rst_no,
  output logic [NUM_CORES-1:0] fetch_enable_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [NUM_CORES-1:0] fail_mask_o,
  output logic [CNT_W-1:0]     cycle_cnt_o
);

  typedef enum logic [1:0] {StResetHold, StFetchWait, StRun, StDone} state_e;

  // Last-edge compare values; FetchLast wraps when the delay is 0 but is then unused.
  localparam int unsigned ResetLastI = RESET_WAIT_CYCLES - 1;
  localparam int unsigned FetchLastI = FETCH_DELAY_CYCLES - 1;
  localparam logic [31:0] ResetLast = ResetLastI;
  localparam logic [31:0] FetchLast = FetchLastI;
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam bit FailFast  = (FAIL_FAST != 0);
  localparam bit HasFetchWait = (FETCH_DELAY_CYCLES != 0);

  state_e               state_q;
  logic [31:0]          wait_q;
  logic                 core_rst_n_q;
  logic [NUM_CORES-1:0] fetch_q;
  logic                 done_q, pass_q, fail_q, timeout_q;
  logic [NUM_CORES-1:0] fail_mask_q;
  logic [NUM_CORES-1:0] passed_q;
  logic [CNT_W-1:0]     cycle_cnt_q;

  logic [NUM_CORES-1:0] failed_next;
  logic [NUM_CORES-1:0] passed_next;
  logic                 all_finished;
  logic                 any_fail;
  logic                 timeout_hit;
  logic [CNT_W-1:0]     cnt_inc;

  // A core that fails in the same cycle it passes is recorded as failed only.
  always_comb begin
    failed_next  = fail_mask_q | tests_failed_i;
    passed_next  = passed_q | (tests_passed_i & ~failed_next);
    all_finished = &(passed_next | failed_next);
    any_fail     = |failed_next;
    timeout_hit  = TimeoutEn && (cycle_cnt_q == TimeoutLast);
    cnt_inc      = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StResetHold;
      wait_q       <= '0;
      core_rst_n_q <= 1'b0;
      fetch_q      <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_mask_q  <= '0;
      passed_q     <= '0;
      cycle_cnt_q  <= '0;
    end else if (rerun_req_i) begin
      state_q      <= StResetHold;
      wait_q       <= '0;
      core_rst_n_q <= 1'b0;
      fetch_q      <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_mask_q  <= '0;
      passed_q     <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StResetHold: begin
          if (wait_q == ResetLast) begin
            core_rst_n_q <= 1'b1;
            wait_q       <= '0;
            if (HasFetchWait) begin
              state_q <= StFetchWait;
            end else begin
              state_q <= StRun;
              fetch_q <= '1;
            end
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        StFetchWait: begin
          if (wait_q == FetchLast) begin
            fetch_q <= '1;
            wait_q  <= '0;
            state_q <= StRun;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        StRun: begin
          cycle_cnt_q <= cnt_inc;
          fail_mask_q <= failed_next;
          passed_q    <= passed_next;
          // Flag verdicts outrank the watchdog when they land on the same edge.
          if (FailFast && any_fail) begin
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            state_q <= StDone;
          end else if (all_finished) begin
            done_q  <= 1'b1;
            pass_q  <= ~any_fail;
            fail_q  <= any_fail;
            state_q <= StDone;
          end else if (timeout_hit) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            fail_q    <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StResetHold;
        end
      endcase
    end
  end

  assign core_rst_no    = core_rst_n_q;
  assign fetch_enable_o = fetch_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign timeout_o      = timeout_q;
  assign fail_mask_o    = fail_mask_q;
  assign cycle_cnt_o    = cycle_cnt_q;

`ifndef SYNTHESIS
  localparam bit TimeoutFits = (CNT_W >= 32) || (64'(TIMEOUT_CYCLES) < (64'd1 << CNT_W));
  localparam bit ParamsOk    = (RESET_WAIT_CYCLES >= 1) && TimeoutFits;

  a_params_ok: assert property (@(posedge clk_i) ParamsOk);
  a_state_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    state_q inside {StResetHold, StFetchWait, StRun, StDone});
  a_verdict_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pass_q && fail_q));
  a_pass_clean: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pass_q |-> (fail_mask_q == '0) && !timeout_q);
`endif

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl: four instances cover default, 4-core fail-fast,
// 4-core wait-all and short-watchdog configurations.
module tb_tb_run_ctrl;

  logic clk, rst_n, rerun;
  logic p1, f1;
  logic [3:0] p4, f4;
  int total, bad;

  logic crn0, d0, ps0, fl0, to0;
  logic [0:0] fe0, m0;
  logic [31:0] c0;
  logic crn1, d1, ps1, fl1, to1;
  logic [3:0] fe1, m1;
  logic [31:0] c1;
  logic crn2, d2, ps2, fl2, to2;
  logic [3:0] fe2, m2;
  logic [31:0] c2;
  logic crn3, d3, ps3, fl3, to3;
  logic [0:0] fe3, m3;
  logic [31:0] c3;

  tb_run_ctrl u0 (
    .clk_i(clk), .rst_ni(rst_n), .rerun_req_i(rerun),
    .tests_passed_i(p1), .tests_failed_i(f1),
    .core_rst_no(crn0), .fetch_enable_o(fe0), .done_o(d0), .pass_o(ps0), .fail_o(fl0),
    .timeout_o(to0), .fail_mask_o(m0), .cycle_cnt_o(c0)
  );

  tb_run_ctrl #(.NUM_CORES(4), .FETCH_DELAY_CYCLES(3), .FAIL_FAST(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .rerun_req_i(rerun),
    .tests_passed_i(p4), .tests_failed_i(f4),
    .core_rst_no(crn1), .fetch_enable_o(fe1), .done_o(d1), .pass_o(ps1), .fail_o(fl1),
    .timeout_o(to1), .fail_mask_o(m1), .cycle_cnt_o(c1)
  );

  tb_run_ctrl #(.NUM_CORES(4), .FETCH_DELAY_CYCLES(3), .FAIL_FAST(0)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .rerun_req_i(rerun),
    .tests_passed_i(p4), .tests_failed_i(f4),
    .core_rst_no(crn2), .fetch_enable_o(fe2), .done_o(d2), .pass_o(ps2), .fail_o(fl2),
    .timeout_o(to2), .fail_mask_o(m2), .cycle_cnt_o(c2)
  );

  tb_run_ctrl #(.TIMEOUT_CYCLES(50)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .rerun_req_i(rerun),
    .tests_passed_i(p1), .tests_failed_i(f1),
    .core_rst_no(crn3), .fetch_enable_o(fe3), .done_o(d3), .pass_o(ps3), .fail_o(fl3),
    .timeout_o(to3), .fail_mask_o(m3), .cycle_cnt_o(c3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    rerun = 1'b0;
    p1 = 1'b0; f1 = 1'b0; p4 = 4'h0; f4 = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rerun = 1'b0;
    p1 = 1'b0; f1 = 1'b0; p4 = 4'h0; f4 = 4'h0;
    tick();
    total++;
    if ({crn0, fe0, d0, ps0, fl0, to0, m0, c0} !== 39'h0) begin
      bad++;
      $display("FAIL reset_u0: got %0h want 0", {crn0, fe0, d0, ps0, fl0, to0, m0, c0});
    end
    total++;
    if ({crn1, fe1, d1, ps1, fl1, to1, m1, c1} !== 45'h0) begin
      bad++;
      $display("FAIL reset_u1: got %0h want 0", {crn1, fe1, d1, ps1, fl1, to1, m1, c1});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (crn0 !== 1'b0) begin
      bad++; $display("FAIL rst_hold_edge3: got %b want 0", crn0);
    end
    tick();
    total++;
    if ({crn0, fe0} !== 2'b11) begin
      bad++; $display("FAIL rst_release_edge4: got %b want 11", {crn0, fe0});
    end
    total++;
    if ({crn1, fe1} !== 5'b1_0000) begin
      bad++; $display("FAIL fetch_wait_entry: got %b want 10000", {crn1, fe1});
    end
    repeat (2) tick();
    total++;
    if (fe1 !== 4'h0) begin
      bad++; $display("FAIL fetch_wait_edge6: got %h want 0", fe1);
    end
    tick();
    total++;
    if ({crn1, fe1, c1} !== {1'b1, 4'hf, 32'd0}) begin
      bad++; $display("FAIL fetch_delay3: got %b %h %0d want 1 f 0", crn1, fe1, c1);
    end
  endtask

  task automatic test_free_run;
    logic seen_done;
    seen_done = 1'b0;
    do_reset();
    repeat (4) tick();
    for (int c = 0; c < 100; c++) begin
      tick();
      seen_done |= d0;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++; $display("FAIL free_run_done: got %b want 0", seen_done);
    end
    total++;
    if (c0 !== 32'd100) begin
      bad++; $display("FAIL free_run_cnt: got %0d want 100", c0);
    end
  endtask

  task automatic test_all_pass;
    do_reset();
    repeat (7) tick();
    for (int c = 0; c <= 40; c++) begin
      p4 = (c == 10) ? 4'h1 : (c == 20) ? 4'h2 : (c == 30) ? 4'h4 : (c == 40) ? 4'h8 : 4'h0;
      tick();
      if (c == 39) begin
        total++;
        if (d1 !== 1'b0) begin
          bad++; $display("FAIL all_pass_early: got %b want 0", d1);
        end
      end
    end
    p4 = 4'h0;
    total++;
    if ({d1, ps1, fl1, to1, m1} !== 8'b1100_0000) begin
      bad++; $display("FAIL all_pass_verdict: got %b want 11000000", {d1, ps1, fl1, to1, m1});
    end
    total++;
    if (c1 !== 32'd41) begin
      bad++; $display("FAIL all_pass_cnt: got %0d want 41", c1);
    end
  endtask

  task automatic test_fail_core2;
    do_reset();
    repeat (7) tick();
    for (int c = 0; c <= 30; c++) begin
      p4 = (c == 10) ? 4'h1 : (c == 20) ? 4'h2 : (c == 30) ? 4'h8 : 4'h0;
      f4 = (c == 15) ? 4'h4 : 4'h0;
      tick();
      if (c == 15) begin
        total++;
        if ({d1, ps1, fl1, m1, c1} !== {3'b101, 4'h4, 32'd16}) begin
          bad++;
          $display("FAIL fail_fast: got %b %h %0d want 101 4 16", {d1, ps1, fl1}, m1, c1);
        end
      end
      if (c == 29) begin
        total++;
        if (d2 !== 1'b0) begin
          bad++; $display("FAIL wait_all_early: got %b want 0", d2);
        end
      end
    end
    p4 = 4'h0;
    f4 = 4'h0;
    total++;
    if ({d2, ps2, fl2, to2, m2, c2} !== {4'b1010, 4'h4, 32'd31}) begin
      bad++;
      $display("FAIL wait_all_verdict: got %b %h %0d want 1010 4 31", {d2, ps2, fl2, to2}, m2, c2);
    end
    total++;
    if (c1 !== 32'd16) begin
      bad++; $display("FAIL done_frozen_cnt: got %0d want 16", c1);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    repeat (4) tick();
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c == 48) begin
        total++;
        if (d3 !== 1'b0) begin
          bad++; $display("FAIL timeout_early: got %b want 0", d3);
        end
      end
    end
    total++;
    if ({d3, ps3, fl3, to3, c3} !== {4'b1011, 32'd50}) begin
      bad++; $display("FAIL timeout_verdict: got %b %0d want 1011 50", {d3, ps3, fl3, to3}, c3);
    end
    do_reset();
    repeat (4) tick();
    for (int c = 0; c < 50; c++) begin
      p1 = (c == 49);
      tick();
    end
    p1 = 1'b0;
    total++;
    if ({d3, ps3, fl3, to3, c3} !== {4'b1100, 32'd50}) begin
      bad++; $display("FAIL pass_beats_timeout: got %b %0d want 1100 50", {d3, ps3, fl3, to3}, c3);
    end
  endtask

  task automatic test_pass_fail_same;
    do_reset();
    repeat (4) tick();
    repeat (5) tick();
    p1 = 1'b1;
    f1 = 1'b1;
    tick();
    p1 = 1'b0;
    f1 = 1'b0;
    total++;
    if ({d0, ps0, fl0, to0, m0} !== 5'b10101) begin
      bad++; $display("FAIL pass_fail_same: got %b want 10101", {d0, ps0, fl0, to0, m0});
    end
  endtask

  task automatic test_rerun;
    do_reset();
    repeat (7) tick();
    repeat (5) tick();
    rerun = 1'b1;
    f4 = 4'hf;
    tick();
    rerun = 1'b0;
    total++;
    if ({crn1, fe1, d1, ps1, fl1, to1, m1, c1} !== 45'h0) begin
      bad++;
      $display("FAIL rerun_mid_run: got %0h want 0", {crn1, fe1, d1, ps1, fl1, to1, m1, c1});
    end
    repeat (3) tick();
    total++;
    if (crn1 !== 1'b0) begin
      bad++; $display("FAIL rerun_hold_edge3: got %b want 0", crn1);
    end
    tick();
    total++;
    if ({crn1, fe1} !== 5'b1_0000) begin
      bad++; $display("FAIL rerun_release_edge4: got %b want 10000", {crn1, fe1});
    end
    repeat (3) tick();
    total++;
    if (fe1 !== 4'hf) begin
      bad++; $display("FAIL rerun_fetch_edge7: got %h want f", fe1);
    end
    f4 = 4'h0;
    repeat (3) tick();
    total++;
    if ({d1, m1, c1} !== {1'b0, 4'h0, 32'd3}) begin
      bad++; $display("FAIL stale_flag_ignored: got %b %h %0d want 0 0 3", d1, m1, c1);
    end
    p4 = 4'hf;
    tick();
    p4 = 4'h0;
    total++;
    if ({d1, ps1, fl1, c1} !== {3'b110, 32'd4}) begin
      bad++; $display("FAIL rerun_replay_pass: got %b %0d want 110 4", {d1, ps1, fl1}, c1);
    end
    rerun = 1'b1;
    tick();
    rerun = 1'b0;
    total++;
    if ({crn1, fe1, d1, ps1, c1} !== 39'h0) begin
      bad++; $display("FAIL rerun_in_done: got %0h want 0", {crn1, fe1, d1, ps1, c1});
    end
    repeat (7) tick();
    f4 = 4'h1;
    rerun = 1'b1;
    tick();
    rerun = 1'b0;
    f4 = 4'h0;
    total++;
    if ({d1, fl1, m1, crn1} !== 7'h0) begin
      bad++; $display("FAIL rerun_beats_done: got %b want 0", {d1, fl1, m1, crn1});
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    repeat (5) tick();
    total++;
    if ({crn1, fe1} !== 5'b1_0000) begin
      bad++; $display("FAIL in_fetch_wait: got %b want 10000", {crn1, fe1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({crn1, fe1, d1, ps1, fl1, to1, m1, c1} !== 45'h0) begin
      bad++;
      $display("FAIL async_reset: got %0h want 0", {crn1, fe1, d1, ps1, fl1, to1, m1, c1});
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (crn1 !== 1'b0) begin
      bad++; $display("FAIL replay_hold_edge3: got %b want 0", crn1);
    end
    tick();
    repeat (2) tick();
    total++;
    if ({crn1, fe1} !== 5'b1_0000) begin
      bad++; $display("FAIL replay_edge6: got %b want 10000", {crn1, fe1});
    end
    tick();
    total++;
    if ({crn1, fe1} !== 5'b1_1111) begin
      bad++; $display("FAIL replay_fetch_edge7: got %b want 11111", {crn1, fe1});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    rerun = 1'b0;
    p1 = 1'b0; f1 = 1'b0; p4 = 4'h0; f4 = 4'h0;
    test_reset();
    test_free_run();
    test_all_pass();
    test_fail_core2();
    test_timeout();
    test_pass_fail_same();
    test_rerun();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
